// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares a single SRAM-style port between the instruction requester (I) and
// the data requester (D). At most one access is issued per cycle; each read
// response (or write completion) is routed back to its owner through a small
// tag pipeline that matches the SRAM read latency.
//
// Arbitration: D has priority. If I keeps losing conflicts, a wait counter
// reaches MAX_WAIT and I is forced to win the next conflict.
//
// Parameters:
//   LATENCY  - cycles from sram_en to valid sram_rdata (1 or 2)
//   MAX_WAIT - consecutive lost-conflict cycles before I is forced (1..15)
//
// Optional build macro:
//   ARB_ADDR_XLATE_EN - when defined, granted addresses in kseg0/kseg1
//                       (0x8000_0000..0xBFFF_FFFF) have bits [31:29] cleared
//                       on sram_addr. Otherwise sram_addr is verbatim.
//
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   i_req/i_addr            - instruction request and address
//   i_addr_ok               - instruction request accepted this cycle
//   i_data_ok/i_rdata       - instruction read data return
//   d_req/d_wen/d_addr/d_wdata - data request (d_wen==0 means read)
//   d_addr_ok               - data request accepted this cycle
//   d_data_ok/d_rdata       - data response (read data or write completion)
//   sram_en/sram_wen/sram_addr/sram_wdata - shared SRAM port
//   sram_rdata              - SRAM read data, valid LATENCY cycles after en
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int LATENCY  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_I    = 2'd1;
  localparam logic [1:0] GNT_D    = 2'd2;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [1:0]         grant;
  logic [3:0]         wait_cnt;
  logic [31:0]        gnt_addr;
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_is_d;

  // ---------------------------------------------------------------------------
  // Grant: purely combinational from the current requests and wait counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    grant = GNT_NONE;
    if (!reset) begin
      if (d_req && !(i_req && (wait_cnt == WAIT_LIMIT))) begin
        grant = GNT_D;
      end else if (i_req) begin
        grant = GNT_I;
      end
    end
  end

  always_comb begin
    gnt_addr   = 32'h0;
    sram_wen   = 4'h0;
    sram_wdata = 32'h0;
    if (grant == GNT_D) begin
      gnt_addr   = d_addr;
      sram_wen   = d_wen;
      sram_wdata = d_wdata;
    end else if (grant == GNT_I) begin
      gnt_addr   = i_addr;
    end
  end

`ifdef ARB_ADDR_XLATE_EN
  // kseg0/kseg1 are exactly the addresses whose top two bits are 2'b10; both
  // map onto physical memory by dropping the segment bits [31:29].
  assign sram_addr = (gnt_addr[31:30] == 2'b10) ? {3'b000, gnt_addr[28:0]}
                                                : gnt_addr;
`else
  assign sram_addr = gnt_addr;
`endif

  assign sram_en   = (grant != GNT_NONE);
  assign i_addr_ok = (grant == GNT_I);
  assign d_addr_ok = (grant == GNT_D);

  // ---------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles I waits while requesting.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always updated with non-blocking assignments so
    // every flop samples the pre-edge values regardless of statement order.
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (i_req && (grant != GNT_I)) begin
      if (wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline: one {valid, owner} stage per cycle of SRAM latency. The last
  // stage lines up with sram_rdata for the access issued LATENCY cycles ago.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the tag stages must be reset (unlike a data RAM) because a stale
    // valid bit would emit a spurious data_ok for an access lost to reset.
    if (reset) begin
      tag_valid <= '0;
      tag_is_d  <= '0;
    end else begin
      tag_valid[0] <= sram_en;
      tag_is_d[0]  <= (grant == GNT_D);
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_is_d[i]  <= tag_is_d[i-1];
      end
    end
  end

  // Outputs are forced low while reset is held.
  assign i_data_ok = !reset && tag_valid[LATENCY-1] && !tag_is_d[LATENCY-1];
  assign d_data_ok = !reset && tag_valid[LATENCY-1] &&  tag_is_d[LATENCY-1];
  assign i_rdata   = reset ? 32'h0 : sram_rdata;
  assign d_rdata   = reset ? 32'h0 : sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Drives two arbiters side by side with identical stimulus: one built with
// LATENCY=1 and one with LATENCY=2 (both MAX_WAIT=4). Each scenario task
// states the grant it expects each cycle; a negedge monitor compares the SRAM
// port and addr_ok outputs against that expectation and compares data_ok /
// rdata against a scoreboard of responses queued when each grant is driven.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic [3:0]  d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] sram_rdata;

  logic        i_addr_ok  [2];
  logic        i_data_ok  [2];
  logic [31:0] i_rdata    [2];
  logic        d_addr_ok  [2];
  logic        d_data_ok  [2];
  logic [31:0] d_rdata    [2];
  logic        sram_en    [2];
  logic [3:0]  sram_wen   [2];
  logic [31:0] sram_addr  [2];
  logic [31:0] sram_wdata [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  // Expected grant this cycle: 0 none, 1 I, 2 D.
  logic [1:0] exp_grant = 2'd0;

  typedef struct {
    int dut;
    int due;
    bit own_d;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] data_fn(input int c);
    return 32'h1234_5678 + (32'(c) * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] xl(input logic [31:0] a);
`ifdef ARB_ADDR_XLATE_EN
    if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
`endif
    return a;
  endfunction

  assign sram_rdata = data_fn(cyc);

  sram_port_arbiter #(.LATENCY(1), .MAX_WAIT(4)) u_lat1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok[0]),
    .i_data_ok(i_data_ok[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok[0]), .d_data_ok(d_data_ok[0]), .d_rdata(d_rdata[0]),
    .sram_en(sram_en[0]), .sram_wen(sram_wen[0]), .sram_addr(sram_addr[0]),
    .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata)
  );

  sram_port_arbiter #(.LATENCY(2), .MAX_WAIT(4)) u_lat2 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok[1]),
    .i_data_ok(i_data_ok[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok[1]), .d_data_ok(d_data_ok[1]), .d_rdata(d_rdata[1]),
    .sram_en(sram_en[1]), .sram_wen(sram_wen[1]), .sram_addr(sram_addr[1]),
    .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Monitor: grant-side outputs against exp_grant, response side against sb.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [70:0] e_port;
        logic [70:0] a_port;
        logic        ei;
        logic        ed;
        e_port = {exp_grant == 2'd1, exp_grant == 2'd2, exp_grant != 2'd0,
                  (exp_grant == 2'd2) ? d_wen : 4'h0,
                  (exp_grant == 2'd2) ? xl(d_addr) :
                  (exp_grant == 2'd1) ? xl(i_addr) : 32'h0,
                  (exp_grant == 2'd2) ? d_wdata : 32'h0};
        a_port = {i_addr_ok[k], d_addr_ok[k], sram_en[k], sram_wen[k],
                  sram_addr[k], sram_wdata[k]};
        n_tests++;
        if (a_port !== e_port) begin
          n_fail++;
          $display("FAIL grant lat%0d cyc %0d: got {iok,dok,en,wen,addr,wdata}=%h expected %h",
                   k + 1, cyc, a_port, e_port);
        end
        ei = 1'b0;
        ed = 1'b0;
        foreach (sb[j]) begin
          if (sb[j].dut == k && sb[j].due == cyc) begin
            if (sb[j].own_d) ed = 1'b1;
            else             ei = 1'b1;
          end
        end
        n_tests++;
        if ({i_data_ok[k], d_data_ok[k]} !== {ei, ed}) begin
          n_fail++;
          $display("FAIL data_ok lat%0d cyc %0d: got {i,d}=%b%b expected %b%b",
                   k + 1, cyc, i_data_ok[k], d_data_ok[k], ei, ed);
        end
        if (ei) begin
          n_tests++;
          if (i_rdata[k] !== data_fn(cyc)) begin
            n_fail++;
            $display("FAIL i_rdata lat%0d cyc %0d: got %h expected %h",
                     k + 1, cyc, i_rdata[k], data_fn(cyc));
          end
        end
        if (ed) begin
          n_tests++;
          if (d_rdata[k] !== data_fn(cyc)) begin
            n_fail++;
            $display("FAIL d_rdata lat%0d cyc %0d: got %h expected %h",
                     k + 1, cyc, d_rdata[k], data_fn(cyc));
          end
        end
      end
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].due <= cyc) sb.delete(j);
      end
    end
  end

  // Records the expected grant for the current cycle (inputs already driven),
  // queues the response it should produce on each DUT, then advances a cycle.
  task automatic step(input logic [1:0] g);
    exp_grant = g;
    if (g != 2'd0) begin
      for (int k = 0; k < 2; k++) begin
        exp_t e;
        e.dut   = k;
        e.due   = cyc + k + 1;
        e.own_d = (g == 2'd2);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_req = 1'b0;
    d_req = 1'b0;
    for (int i = 0; i < n; i++) step(2'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset   = 1'b1;
    sb.delete();
    i_req   = 1'b1;
    i_addr  = 32'h0000_0040;
    d_req   = 1'b1;
    d_wen   = 4'hF;
    d_addr  = 32'h0000_0080;
    d_wdata = 32'hCAFE_F00D;
    #2;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if ({i_rdata[k], d_rdata[k]} !== 64'h0) begin
        n_fail++;
        $display("FAIL reset_rdata lat%0d: got %h/%h expected 0/0",
                 k + 1, i_rdata[k], d_rdata[k]);
      end
    end
    step(2'd0);
    step(2'd0);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_instr_only();
    i_req  = 1'b1;
    i_addr = 32'h0000_1000;
    d_req  = 1'b0;
    step(2'd1);
    idle(3);
  endtask

  task automatic test_conflict();
    i_req   = 1'b1;
    i_addr  = 32'h0000_1004;
    d_req   = 1'b1;
    d_wen   = 4'hF;
    d_addr  = 32'h0000_2000;
    d_wdata = 32'hDEAD_BEEF;
    step(2'd2);
    d_req = 1'b0;
    step(2'd1);
    idle(3);
  endtask

  task automatic test_starvation();
    i_req   = 1'b1;
    i_addr  = 32'h0000_3000;
    d_req   = 1'b1;
    d_wen   = 4'h0;
    d_addr  = 32'h0000_4000;
    d_wdata = 32'h0;
    for (int n = 0; n < 15; n++) begin
      d_addr = 32'h0000_4000 + 32'(n * 4);
      step((n % 5 == 4) ? 2'd1 : 2'd2);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    i_req  = 1'b1;
    i_addr = 32'h0000_5000;
    d_req  = 1'b0;
    step(2'd1);
    i_req   = 1'b0;
    d_req   = 1'b1;
    d_wen   = 4'h0;
    d_addr  = 32'h0000_6000;
    step(2'd2);
    d_req  = 1'b0;
    i_req  = 1'b1;
    i_addr = 32'h0000_5004;
    step(2'd1);
    // Partial-byte write immediately after the fetch.
    i_req   = 1'b0;
    d_req   = 1'b1;
    d_wen   = 4'h3;
    d_addr  = 32'h0000_6004;
    d_wdata = 32'h0000_A5A5;
    step(2'd2);
    idle(3);
  endtask

  task automatic test_reset_midflight();
    // Build up wait_cnt to 3 before the reset.
    i_req   = 1'b1;
    i_addr  = 32'h0000_7000;
    d_req   = 1'b1;
    d_wen   = 4'h0;
    d_addr  = 32'h0000_8000;
    d_wdata = 32'h0;
    step(2'd2);
    step(2'd2);
    step(2'd2);
    reset = 1'b1;
    sb.delete();
    step(2'd0);
    reset = 1'b0;
    // A cleared counter means D wins four more times before I is forced.
    for (int n = 0; n < 5; n++) step((n == 4) ? 2'd1 : 2'd2);
    idle(3);
  endtask

  task automatic test_addr_xlate();
    logic [31:0] addrs [4];
    addrs[0] = 32'hBFC0_0000;
    addrs[1] = 32'h8000_0100;
    addrs[2] = 32'h0040_0000;
    addrs[3] = 32'hC000_0000;
    d_req = 1'b0;
    for (int n = 0; n < 4; n++) begin
      i_req  = 1'b1;
      i_addr = addrs[n];
      step(2'd1);
    end
    i_req   = 1'b0;
    d_req   = 1'b1;
    d_wen   = 4'hC;
    d_addr  = 32'hA000_0010;
    d_wdata = 32'h1357_9BDF;
    step(2'd2);
    d_addr  = 32'h7FFF_FFFC;
    step(2'd2);
    idle(3);
  endtask

  initial begin
    reset   = 1'b1;
    i_req   = 1'b0;
    i_addr  = 32'h0;
    d_req   = 1'b0;
    d_wen   = 4'h0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    test_reset();
    test_instr_only();
    test_conflict();
    test_starvation();
    test_back_to_back();
    test_reset_midflight();
    test_addr_xlate();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one SRAM-style port (en/wen/addr/wdata, read data returned a fixed latency later) between the core's instruction requester and its data requester.
- Issues at most one access per cycle and routes each response back to its owner through a tag pipeline.
- Data requests have priority; a bounded-wait counter prevents instruction-fetch starvation.
- Sits between the bus-to-SRAM converters and the top-level SRAM pins.

Parameters:
- LATENCY, 1: cycles from sram_en to valid sram_rdata; legal values 1 or 2.
- MAX_WAIT, 4: consecutive lost-conflict cycles after which the instruction side is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_req  in  1  instruction request valid; held stable until i_addr_ok
- i_addr  in  32  instruction address
- i_addr_ok  out  1  instruction request accepted this cycle
- i_data_ok  out  1  instruction read data valid this cycle
- i_rdata  out  32  instruction read data
- d_req  in  1  data request valid; held stable until d_addr_ok
- d_wen  in  4  byte write enables; 0 means read
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_addr_ok  out  1  data request accepted this cycle
- d_data_ok  out  1  data response (read data or write completion) this cycle
- d_rdata  out  32  data read data
- sram_en  out  1  SRAM access enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid LATENCY cycles after sram_en

Behaviour:
- Clock is clk. Reset is synchronous and active-high: it is sampled on the rising edge of clk and takes effect there.
- Grant is combinational from the current i_req, d_req and starvation state. Both addr_ok and sram_en assert in the same cycle as the grant.
  - Only i_req: grant I.
  - Only d_req: grant D.
  - Both: grant D, unless wait_cnt == MAX_WAIT, in which case grant I.
  - Neither: no grant. sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0.
- Granting I drives: sram_wen=0, sram_addr=i_addr, sram_wdata=0, i_addr_ok=1.
- Granting D drives: d_wen, d_addr, d_wdata onto the SRAM port, d_addr_ok=1.
- wait_cnt is 4 bits.
  - Increments (saturating at MAX_WAIT) on each cycle where i_req=1 and I is not granted.
  - Clears on an I grant or when i_req=0.
- Tag pipeline: LATENCY stages of {valid, owner}. Stage 0 captures {sram_en, grant==D} each cycle; each stage shifts on every cycle.
- At the last stage:
  - valid & owner==I: i_data_ok=1.
  - valid & owner==D: d_data_ok=1. Writes also receive d_data_ok.
  - i_rdata and d_rdata are both driven by sram_rdata every cycle; they are meaningful only with the matching data_ok.
- Throughput is one access per cycle. A data_ok for an old access and an addr_ok for a new access may occur in the same cycle, on the same or different sides.
- Reset values: tag pipeline all invalid, wait_cnt=0. During reset all outputs are 0, no grant is issued, and *_addr_ok=0.
- Reset mid-operation: in-flight responses are discarded; no data_ok is emitted after reset deasserts for accesses issued before it.
- Requests are not queued. A requester whose req is not granted keeps req high; this is a requester obligation and is not checked.

Optional Feature:
- ARB_ADDR_XLATE_EN:
  - When defined, sram_addr applies fixed MIPS segment translation to the granted address: addresses 0x8000_0000–0xBFFF_FFFF (kseg0/kseg1) have bits [31:29] cleared; all other addresses pass unchanged.
  - When undefined, sram_addr is the granted address verbatim.
  - Grant, tag and counter logic are identical in both builds.

Test Plan:
- Instruction only, LATENCY=1: i_req=1, i_addr=0x0000_1000, sram_rdata=0x1234_5678 next cycle -> i_addr_ok=1 and sram_en=1 in cycle 0; i_data_ok=1 and i_rdata=0x1234_5678 in cycle 1; d_* outputs stay 0.
- Conflict: i_req=1 and d_req=1 (d_wen=0xF, d_addr=0x2000, d_wdata=0xDEAD_BEEF) in the same cycle -> d_addr_ok=1, sram_wen=0xF, sram_wdata=0xDEAD_BEEF; i_addr_ok=0; the following cycle d_data_ok=1.
- Starvation, MAX_WAIT=4: i_req and d_req held high continuously -> D granted for 4 consecutive cycles, I granted in the 5th cycle, then D again; pattern repeats every 5 cycles.
- Back-to-back with LATENCY=2: I, D, I granted in cycles 0, 1, 2 -> i_data_ok in cycle 2, d_data_ok in cycle 3, i_data_ok in cycle 4; each rdata equals sram_rdata in its cycle.
- Reset mid-flight: D read granted in cycle 0 with LATENCY=2, reset=1 in cycle 1 -> no d_data_ok in cycles 1–3; wait_cnt reads 0 after reset.
- ARB_ADDR_XLATE_EN defined: i_addr=0xBFC0_0000 -> sram_addr=0x1FC0_0000. i_addr=0x8000_0100 -> sram_addr=0x0000_0100. i_addr=0x0040_0000 -> sram_addr=0x0040_0000.
